// File: rtl/fifo_pkg.sv
// Shared types, defaults and helpers for the parametrised single-clock FIFO.
// Imported by the pointer counter and the FIFO top.
package fifo_pkg;

  typedef enum logic [0:0] {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int unsigned DefDataW       = 8;
  localparam int unsigned DefDepth       = 16;
  localparam int unsigned DefAfullMargin = 2;
  localparam int unsigned DefAemptyTh    = 2;

  // Pointer width including the wrap bit that tells full from empty.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Wrap-bit pointer counter with synchronous clear and asynchronous reset.
// The MSB is the wrap bit; the low bits address the storage array.
module fifo_ptr_ctr
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_W = ptr_w(DefDepth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Clear wins over increment so a flush drops the same-cycle request.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sp_fifo_param.sv
// Parametrised single-clock FIFO with status flags, error pulses, flush and an
// optional first-word-fall-through read port.
module sp_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned AFULL_TH  = DEPTH - DefAfullMargin,
  parameter int unsigned AEMPTY_TH = DefAemptyTh,
  parameter fifo_mode_e  FWFT      = FIFO_STD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        din,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  output logic [$clog2(DEPTH)-1:0] wr_addr_count,
  output logic [$clog2(DEPTH)-1:0] rd_addr_count
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned AW    = PTR_W - 1;
  localparam logic [PTR_W-1:0] DepthCnt = PTR_W'(DEPTH);

  if (DATA_W < 1) begin : g_bad_width
    $fatal(1, "sp_fifo_param: DATA_W must be at least 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sp_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $fatal(1, "sp_fifo_param: AFULL_TH out of range 1..DEPTH");
  end
  if (AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $fatal(1, "sp_fifo_param: AEMPTY_TH out of range 0..DEPTH-1");
  end

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic [PTR_W-1:0]  count_w;
  logic              full_w, empty_w;
  logic              wr_acc, rd_acc;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // Occupancy from the wrap-bit pointers; modular subtraction handles wrap.
  always_comb begin
    count_w = wr_ptr - rd_ptr;
    full_w  = (count_w == DepthCnt);
    empty_w = (count_w == '0);
  end

  // Acceptance looks only at the registered state, never at the other port.
  always_comb begin
    wr_acc      = wr_en & ~full_w & ~flush;
    rd_acc      = rd_en & ~empty_w & ~flush;
    overflow_d  = wr_en & full_w & ~flush;
    underflow_d = rd_en & empty_w & ~flush;
  end

  fifo_ptr_ctr #(
    .PTR_W (PTR_W)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc),
    .clr (flush),
    .ptr (wr_ptr)
  );

  fifo_ptr_ctr #(
    .PTR_W (PTR_W)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc),
    .clr (flush),
    .ptr (rd_ptr)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_acc) begin
      mem_d[wr_idx] = din;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  if (FWFT == FIFO_STD) begin : g_std
    logic [DATA_W-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_acc) begin
        dout_d = mem_q[rd_idx];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign dout = dout_q;
  end else begin : g_fwft
    // Head of queue shown directly; only meaningful while not empty.
    assign dout = mem_q[rd_idx];
  end

  always_comb begin
    count         = count_w;
    full          = full_w;
    empty         = empty_w;
    almost_full   = (32'(count_w) >= AFULL_TH);
    almost_empty  = (32'(count_w) <= AEMPTY_TH);
    overflow      = overflow_q;
    underflow     = underflow_q;
    wr_addr_count = wr_idx;
    rd_addr_count = rd_idx;
  end

endmodule

// File: tb/tb_sp_fifo_param.sv
// Bench for sp_fifo_param: a 16-deep registered-read FIFO and a 4-deep FWFT FIFO
// share one stimulus stream and are compared against queue-based models.
module tb_sp_fifo_param;
  import fifo_pkg::*;

  localparam int DA = 16;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst, flush, wr_en, rd_en;
  logic [7:0] din;

  logic [7:0] dout_a, dout_b;
  logic       full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic       full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [4:0] count_a;
  logic [2:0] count_b;
  logic [3:0] wa_a, ra_a;
  logic [1:0] wa_b, ra_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sp_fifo_param #(
    .DATA_W (8), .DEPTH (DA), .AFULL_TH (14), .AEMPTY_TH (2), .FWFT (FIFO_STD)
  ) u_dut_a (
    .clk (clk), .rst (rst), .flush (flush), .wr_en (wr_en), .din (din), .rd_en (rd_en),
    .dout (dout_a), .full (full_a), .empty (empty_a), .almost_full (af_a),
    .almost_empty (ae_a), .count (count_a), .overflow (ovf_a), .underflow (unf_a),
    .wr_addr_count (wa_a), .rd_addr_count (ra_a)
  );

  sp_fifo_param #(
    .DATA_W (8), .DEPTH (DB), .AFULL_TH (3), .AEMPTY_TH (1), .FWFT (FIFO_FWFT)
  ) u_dut_b (
    .clk (clk), .rst (rst), .flush (flush), .wr_en (wr_en), .din (din), .rd_en (rd_en),
    .dout (dout_b), .full (full_b), .empty (empty_b), .almost_full (af_b),
    .almost_empty (ae_b), .count (count_b), .overflow (ovf_b), .underflow (unf_b),
    .wr_addr_count (wa_b), .rd_addr_count (ra_b)
  );

  // Reference models: plain queues plus counts of accepted operations.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] da;
  logic       ova, una, ovb, unb;
  int         wca, rca, wcb, rcb;

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       fl;
    int         cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    da  = 8'h00;
    ova = 1'b0; una = 1'b0; ovb = 1'b0; unb = 1'b0;
    wca = 0; rca = 0; wcb = 0; rcb = 0;
  endtask

  task automatic model_step();
    bit fa, ea, fb, eb;
    if (flush) begin
      qa.delete(); qb.delete();
      ova = 1'b0; una = 1'b0; ovb = 1'b0; unb = 1'b0;
      wca = 0; rca = 0; wcb = 0; rcb = 0;
    end else begin
      fa = (qa.size() == DA); ea = (qa.size() == 0);
      fb = (qb.size() == DB); eb = (qb.size() == 0);
      ova = wr_en && fa; una = rd_en && ea;
      ovb = wr_en && fb; unb = rd_en && eb;
      if (rd_en && !ea) begin da = qa.pop_front(); rca = (rca + 1) % DA; end
      if (wr_en && !fa) begin qa.push_back(din);   wca = (wca + 1) % DA; end
      if (rd_en && !eb) begin void'(qb.pop_front()); rcb = (rcb + 1) % DB; end
      if (wr_en && !fb) begin qb.push_back(din);   wcb = (wcb + 1) % DB; end
    end
  endtask

  task automatic check_models();
    chk("a_count", count_a, qa.size());
    chk("a_full", full_a, qa.size() == DA);
    chk("a_empty", empty_a, qa.size() == 0);
    chk("a_afull", af_a, qa.size() >= 14);
    chk("a_aempty", ae_a, qa.size() <= 2);
    chk("a_overflow", ovf_a, ova);
    chk("a_underflow", unf_a, una);
    chk("a_dout", dout_a, da);
    chk("a_wr_addr", wa_a, wca);
    chk("a_rd_addr", ra_a, rca);
    chk("b_count", count_b, qb.size());
    chk("b_full", full_b, qb.size() == DB);
    chk("b_empty", empty_b, qb.size() == 0);
    chk("b_afull", af_b, qb.size() >= 3);
    chk("b_aempty", ae_b, qb.size() <= 1);
    chk("b_overflow", ovf_b, ovb);
    chk("b_underflow", unf_b, unb);
    chk("b_wr_addr", wa_b, wcb);
    chk("b_rd_addr", ra_b, rcb);
    if (qb.size() > 0) chk("b_dout", dout_b, qb[0]);
  endtask

  // One clock: model sees the inputs present at the edge; outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_models();
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic f);
    wr_en = w; din = d; rd_en = r; flush = f;
  endtask

  initial begin
    vec_t v;
    // Fill 0..15, reject 0xAA at full, drain 0..15, reject a read at empty.
    for (int i = 0; i < 16; i++) begin
      v = '{wr: 1'b1, din: 8'(i), rd: 1'b0, fl: 1'b0, cnt: i + 1, full: (i + 1 == 16),
            empty: 1'b0, af: (i + 1 >= 14), ae: (i + 1 <= 2), ovf: 1'b0, unf: 1'b0,
            dout: 8'h00};
      vecs.push_back(v);
    end
    vecs.push_back('{1'b1, 8'hAA, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    for (int k = 0; k < 16; k++) begin
      v = '{wr: 1'b0, din: 8'h00, rd: 1'b1, fl: 1'b0, cnt: 15 - k, full: 1'b0,
            empty: (k == 15), af: (15 - k >= 14), ae: (15 - k <= 2), ovf: 1'b0, unf: 1'b0,
            dout: 8'(k)};
      vecs.push_back(v);
    end
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0F});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0F});

    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    model_reset();
    #12;
    chk("rst_count", count_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_aempty", ae_a, 1);
    chk("rst_afull", af_a, 0);
    chk("rst_overflow", ovf_a, 0);
    chk("rst_underflow", unf_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_wr_addr", wa_a, 0);
    chk("rst_b_empty", empty_b, 1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].fl);
      tick();
      chk($sformatf("tv%0d_count", i), count_a, vecs[i].cnt);
      chk($sformatf("tv%0d_full", i), full_a, vecs[i].full);
      chk($sformatf("tv%0d_empty", i), empty_a, vecs[i].empty);
      chk($sformatf("tv%0d_afull", i), af_a, vecs[i].af);
      chk($sformatf("tv%0d_aempty", i), ae_a, vecs[i].ae);
      chk($sformatf("tv%0d_overflow", i), ovf_a, vecs[i].ovf);
      chk($sformatf("tv%0d_underflow", i), unf_a, vecs[i].unf);
      chk($sformatf("tv%0d_dout", i), dout_a, vecs[i].dout);
    end

    // Steady state at count 8 with simultaneous read and write across the wrap.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(8'h48 + i), 1'b1, 1'b0);
      tick();
      chk("rw_count", count_a, 8);
      chk("rw_dout", dout_a, 8'(8'h40 + i));
    end

    // FWFT head visibility and pop.
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    tick();
    chk("fwft_dout_5a", dout_b, 8'h5A);
    chk("fwft_not_empty", empty_b, 0);
    drive(1'b1, 8'h5B, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    chk("fwft_dout_5b", dout_b, 8'h5B);
    tick();
    chk("fwft_empty", empty_b, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Flush beats a same-cycle write, then asynchronous reset mid-cycle.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    tick();
    chk("flush_count", count_a, 0);
    chk("flush_empty", empty_a, 1);
    chk("flush_overflow", ovf_a, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_count_a", count_a, 0);
    chk("arst_empty_a", empty_a, 1);
    chk("arst_count_b", count_b, 0);
    chk("arst_empty_b", empty_b, 1);
    chk("arst_dout_a", dout_a, 0);
    model_reset();
    #1;
    rst = 1'b0;

    // Randomised traffic with phases biased toward filling, draining and balance.
    for (int blk = 0; blk < 30; blk++) begin
      int pw;
      pw = (blk % 3 == 0) ? 80 : ((blk % 3 == 1) ? 20 : 50);
      for (int i = 0; i < 100; i++) begin
        drive($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < (100 - pw),
              $urandom_range(0, 99) == 0);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
